// File: rtl/fir_stream_sequencer_if.sv
// rtl/fir_stream_sequencer_if.sv - signal bundle between the FIR sequencer and its environment
//
// Purpose: groups the sample stream, configuration port, MAC control bus and
// result stream of fir_stream_sequencer into a single interface.
// Ports (signals):
//   in_data/in_valid/in_ready       input sample stream
//   cfg_we/cfg_n/cfg_s              configuration write port
//   x_out/ldx/stm/mac_n/mac_s       delay-line and MAC control
//   mac_y/mac_eof                   MAC result and end-of-filter flag
//   out_data/out_valid/out_ready    filtered sample stream
//   busy/err/sample_cnt             status
// Modports: slave = sequencer view, master = environment view.
interface fir_stream_sequencer_if #(
  parameter int bits_X = 16,
  parameter int bits_Y = 16,
  parameter int bits_N = 3,
  parameter int bits_S = 6
);
  logic [bits_X-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              cfg_we;
  logic [bits_N-1:0] cfg_n;
  logic [bits_S-1:0] cfg_s;
  logic [bits_X-1:0] x_out;
  logic              ldx;
  logic              stm;
  logic [bits_N-1:0] mac_n;
  logic [bits_S-1:0] mac_s;
  logic [bits_Y-1:0] mac_y;
  logic              mac_eof;
  logic [bits_Y-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              err;
  logic [15:0]       sample_cnt;

  modport slave (
    input  in_data, in_valid, cfg_we, cfg_n, cfg_s, mac_y, mac_eof, out_ready,
    output in_ready, x_out, ldx, stm, mac_n, mac_s, out_data, out_valid,
           busy, err, sample_cnt
  );

  modport master (
    output in_data, in_valid, cfg_we, cfg_n, cfg_s, mac_y, mac_eof, out_ready,
    input  in_ready, x_out, ldx, stm, mac_n, mac_s, out_data, out_valid,
           busy, err, sample_cnt
  );
endinterface

// File: rtl/fir_stream_sequencer.sv
// rtl/fir_stream_sequencer.sv - one-sample-at-a-time sequencer for the FIR datapath
//
// Purpose: accepts a sample, pulses the delay-line load, starts the MAC, waits
// for its end-of-filter flag (with a watchdog), and holds the result until the
// downstream accepts it. Holds the tap-count/shift configuration.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   fir_stream_sequencer_if.slave (streams, config, MAC bus, status)
module fir_stream_sequencer #(
  parameter int bits_X  = 16,
  parameter int bits_Y  = 16,
  parameter int bits_N  = 3,
  parameter int bits_S  = 6,
  parameter int bits_T  = 8,
  parameter int TIMEOUT = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  fir_stream_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_START,
    S_WAIT,
    S_OUT
  } state_t;

  localparam logic [bits_T-1:0] WD_LAST = bits_T'(TIMEOUT - 1);
  localparam logic [bits_N-1:0] N_RESET = bits_N'(5);

  state_t            r_state;
  logic [bits_X-1:0] r_x_out;
  logic              r_ldx;
  logic              r_stm;
  logic [bits_Y-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_err;
  logic [15:0]       r_sample_cnt;
  logic [bits_T-1:0] r_watchdog;
  logic [bits_N-1:0] r_n_q;
  logic [bits_S-1:0] r_s_q;
  logic              w_idle;

  assign w_idle = (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_x_out      <= '0;
      r_ldx        <= 1'b0;
      r_stm        <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_err        <= 1'b0;
      r_sample_cnt <= '0;
      r_watchdog   <= '0;
      r_n_q        <= N_RESET;
      r_s_q        <= '0;
    end else begin
      // ldx/stm are set on the transition into SHIFT/START so each is a
      // single-cycle registered pulse aligned with that state.
      r_ldx <= 1'b0;
      r_stm <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Config written alongside a sample is picked up by that sample,
          // since mac_n/mac_s follow the registers directly.
          if (bus.cfg_we) begin
            r_n_q <= bus.cfg_n;
            r_s_q <= bus.cfg_s;
          end
          if (bus.in_valid) begin
            r_x_out <= bus.in_data;
            r_ldx   <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_stm   <= 1'b1;
          r_state <= S_START;
        end
        S_START: begin
          r_watchdog <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          // End-of-filter wins over a timeout landing on the same cycle.
          if (bus.mac_eof) begin
            r_out_data   <= bus.mac_y;
            r_out_valid  <= 1'b1;
            r_sample_cnt <= r_sample_cnt + 16'd1;
            r_state      <= S_OUT;
          end else if (r_watchdog == WD_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_watchdog <= r_watchdog + 1'b1;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = w_idle;
  assign bus.busy       = ~w_idle;
  assign bus.x_out      = r_x_out;
  assign bus.ldx        = r_ldx;
  assign bus.stm        = r_stm;
  assign bus.mac_n      = r_n_q;
  assign bus.mac_s      = r_s_q;
  assign bus.out_data   = r_out_data;
  assign bus.out_valid  = r_out_valid;
  assign bus.err        = r_err;
  assign bus.sample_cnt = r_sample_cnt;
endmodule

// File: tb/tb_fir_stream_sequencer.sv
// tb/tb_fir_stream_sequencer.sv - self-checking bench for fir_stream_sequencer
module tb_fir_stream_sequencer;
  localparam int TIMEOUT = 200;

  logic clk;
  logic rst;
  fir_stream_sequencer_if bus ();

  fir_stream_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // MAC model controls and observation counters
  int          mac_en   = 1;
  int          mac_lat  = 6;
  int          mac_mode = 0;
  int          mac_cnt  = 0;
  logic [15:0] mac_val  = '0;
  int          ldx_cnt  = 0;
  int          stm_cnt  = 0;
  int          both_cnt = 0;
  int          acc      = 0;
  logic [15:0] exp_cnt  = '0;
  logic [15:0] in_q[$];
  logic [15:0] out_q[$];

  function automatic logic [15:0] mac_fn(int mode, logic [15:0] x);
    case (mode)
      0:       return 16'h0ABC;
      1:       return 16'(x * 2);
      default: return (x ^ 16'h5A5A) + 16'd3;
    endcase
  endfunction

  // One clock: record handshakes that will occur at this edge, advance, then
  // play the MAC: an stm pulse schedules mac_eof mac_lat cycles later.
  task automatic step();
    if (!rst && bus.out_valid && bus.out_ready) out_q.push_back(bus.out_data);
    if (!rst && bus.in_valid && bus.in_ready) begin
      acc++;
      in_q.push_back(bus.in_data);
    end
    @(posedge clk);
    #1;
    bus.mac_eof = 1'b0;
    if (mac_cnt > 0) begin
      mac_cnt--;
      if (mac_cnt == 0) begin
        bus.mac_eof = 1'b1;
        bus.mac_y   = mac_val;
      end
    end
    if (bus.stm && mac_en != 0) begin
      mac_cnt = mac_lat;
      mac_val = mac_fn(mac_mode, bus.x_out);
    end
    if (bus.ldx) ldx_cnt++;
    if (bus.stm) stm_cnt++;
    if (bus.ldx && bus.stm) both_cnt++;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (bus.busy && n < 400) begin
      step();
      n++;
    end
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL %s_idle_timeout busy=%b want 0", name, bus.busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_total++;
    if ({bus.x_out, bus.ldx, bus.stm, bus.out_data, bus.out_valid, bus.err, bus.sample_cnt} !== '0)
      $display("FAIL reset_outputs x=%h ldx=%b stm=%b od=%h ov=%b err=%b cnt=%h want all 0",
               bus.x_out, bus.ldx, bus.stm, bus.out_data, bus.out_valid, bus.err, bus.sample_cnt);
    else n_pass++;
    n_total++;
    if (bus.mac_n !== 3'd5 || bus.mac_s !== 6'd0)
      $display("FAIL reset_cfg mac_n=%0d mac_s=%0d want 5 0", bus.mac_n, bus.mac_s);
    else n_pass++;
    n_total++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL reset_idle in_ready=%b busy=%b want 1 0", bus.in_ready, bus.busy);
    else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int n;
    mac_mode = 0;
    mac_lat  = 6;
    bus.out_ready = 1'b0;
    bus.in_data   = 16'h1234;
    bus.in_valid  = 1'b1;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL single_in_ready got %b want 1", bus.in_ready);
    else n_pass++;
    step();
    bus.in_valid = 1'b0;
    n_total++;
    if (bus.x_out !== 16'h1234 || bus.ldx !== 1'b1 || bus.stm !== 1'b0)
      $display("FAIL single_shift x_out=%h ldx=%b stm=%b want 1234 1 0", bus.x_out, bus.ldx, bus.stm);
    else n_pass++;
    step();
    n_total++;
    if (bus.stm !== 1'b1 || bus.ldx !== 1'b0)
      $display("FAIL single_start stm=%b ldx=%b want 1 0", bus.stm, bus.ldx);
    else n_pass++;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      step();
      n++;
    end
    // eof 6 cycles after the stm cycle, out_valid registered one cycle later
    n_total++;
    if (n != 7) $display("FAIL single_latency got %0d cycles want 7", n);
    else n_pass++;
    exp_cnt = exp_cnt + 16'd1;
    n_total++;
    if (bus.out_data !== 16'h0ABC || bus.sample_cnt !== exp_cnt || bus.busy !== 1'b1)
      $display("FAIL single_result od=%h cnt=%0d busy=%b want 0abc %0d 1",
               bus.out_data, bus.sample_cnt, bus.busy, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0ABC || bus.in_ready !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL bp_hold got %0d bad cycles want 0", bad);
    else n_pass++;
    bus.out_ready = 1'b1;
    step();
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL bp_release out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int a0 = acc;
    int l0 = ldx_cnt;
    int s0 = stm_cnt;
    int n  = 0;
    logic [15:0] d;
    mac_mode = 1;
    out_q.delete();
    in_q.delete();
    bus.out_ready = 1'b1;
    while ((out_q.size() < 8 || bus.busy) && n < 400) begin
      bus.in_valid = (acc - a0) < 8;
      bus.in_data  = 16'(acc - a0 + 1);
      mac_lat = $urandom_range(1, 5);
      step();
      n++;
    end
    bus.in_valid = 1'b0;
    n_total++;
    if (out_q.size() != 8) $display("FAIL b2b_count got %0d want 8", out_q.size());
    else n_pass++;
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      d = 16'((i + 1) * 2);
      n_total++;
      if (out_q[i] !== d) $display("FAIL b2b_out[%0d] got %0d want %0d", i, out_q[i], d);
      else n_pass++;
    end
    exp_cnt = exp_cnt + 16'd8;
    n_total++;
    if (ldx_cnt - l0 != 8 || stm_cnt - s0 != 8 || bus.sample_cnt !== exp_cnt)
      $display("FAIL b2b_pulses ldx=%0d stm=%0d cnt=%0d want 8 8 %0d",
               ldx_cnt - l0, stm_cnt - s0, bus.sample_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_random_stream();
    int a0 = acc;
    int n  = 0;
    logic [15:0] d;
    mac_mode = 2;
    out_q.delete();
    in_q.delete();
    while ((acc - a0 < 20 || bus.busy) && n < 3000) begin
      bus.in_valid  = (acc - a0 < 20) && ($urandom_range(0, 3) != 0);
      bus.in_data   = 16'($urandom);
      bus.out_ready = $urandom_range(0, 2) != 0;
      mac_lat = $urandom_range(1, 8);
      step();
      n++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n_total++;
    if (out_q.size() != 20 || in_q.size() != 20)
      $display("FAIL rand_count out=%0d in=%0d want 20 20", out_q.size(), in_q.size());
    else n_pass++;
    for (int i = 0; i < out_q.size() && i < in_q.size(); i++) begin
      d = mac_fn(2, in_q[i]);
      n_total++;
      if (out_q[i] !== d) $display("FAIL rand_out[%0d] got %h want %h", i, out_q[i], d);
      else n_pass++;
    end
    exp_cnt = exp_cnt + 16'd20;
    n_total++;
    if (bus.sample_cnt !== exp_cnt || both_cnt != 0)
      $display("FAIL rand_cnt cnt=%0d overlap=%0d want %0d 0", bus.sample_cnt, both_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_config();
    mac_mode = 1;
    bus.cfg_we = 1'b1;
    bus.cfg_n  = 3'd3;
    bus.cfg_s  = 6'd4;
    step();
    bus.cfg_we = 1'b0;
    n_total++;
    if (bus.mac_n !== 3'd3 || bus.mac_s !== 6'd4)
      $display("FAIL cfg_idle mac_n=%0d mac_s=%0d want 3 4", bus.mac_n, bus.mac_s);
    else n_pass++;
    mac_lat = 20;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0021;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    bus.cfg_we = 1'b1;
    bus.cfg_n  = 3'd7;
    bus.cfg_s  = 6'd9;
    step();
    bus.cfg_we = 1'b0;
    n_total++;
    if (bus.mac_n !== 3'd3 || bus.mac_s !== 6'd4)
      $display("FAIL cfg_wait mac_n=%0d mac_s=%0d want 3 4", bus.mac_n, bus.mac_s);
    else n_pass++;
    wait_idle("cfg1");
    mac_lat = 2;
    bus.cfg_we   = 1'b1;
    bus.cfg_n    = 3'd6;
    bus.cfg_s    = 6'd2;
    bus.in_valid = 1'b1;
    step();
    bus.cfg_we   = 1'b0;
    bus.in_valid = 1'b0;
    n_total++;
    if (bus.mac_n !== 3'd6 || bus.mac_s !== 6'd2 || bus.ldx !== 1'b1)
      $display("FAIL cfg_with_sample mac_n=%0d mac_s=%0d ldx=%b want 6 2 1", bus.mac_n, bus.mac_s, bus.ldx);
    else n_pass++;
    wait_idle("cfg2");
    exp_cnt = exp_cnt + 16'd2;
    n_total++;
    if (bus.sample_cnt !== exp_cnt) $display("FAIL cfg_cnt got %0d want %0d", bus.sample_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    int n = 0;
    mac_en = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0055;
    step();
    bus.in_valid = 1'b0;
    step();
    // first step enters WAIT, then TIMEOUT cycles of WAIT
    while (!bus.err && n < 400) begin
      step();
      n++;
    end
    n_total++;
    if (n != TIMEOUT + 1) $display("FAIL wd_cycles got %0d want %0d", n - 1, TIMEOUT);
    else n_pass++;
    n_total++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL wd_abort busy=%b ov=%b in_ready=%b want 0 0 1", bus.busy, bus.out_valid, bus.in_ready);
    else n_pass++;
    bus.mac_eof = 1'b1;
    bus.mac_y   = 16'hBEEF;
    step();
    step();
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sample_cnt !== exp_cnt)
      $display("FAIL wd_late_eof ov=%b busy=%b cnt=%0d want 0 0 %0d",
               bus.out_valid, bus.busy, bus.sample_cnt, exp_cnt);
    else n_pass++;
    mac_en  = 1;
    mac_lat = 3;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_idle("wd");
    exp_cnt = exp_cnt + 16'd1;
    n_total++;
    if (bus.err !== 1'b1 || bus.sample_cnt !== exp_cnt)
      $display("FAIL wd_sticky err=%b cnt=%0d want 1 %0d", bus.err, bus.sample_cnt, exp_cnt);
    else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = '0;
    n_total++;
    if (bus.err !== 1'b0) $display("FAIL wd_rst_clear err=%b want 0", bus.err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    int ov = 0;
    bus.cfg_we = 1'b1;
    bus.cfg_n  = 3'd2;
    bus.cfg_s  = 6'd7;
    mac_lat = 20;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0F0F;
    step();
    bus.cfg_we   = 1'b0;
    bus.in_valid = 1'b0;
    step();
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_total++;
    if ({bus.x_out, bus.ldx, bus.stm, bus.out_data, bus.out_valid, bus.err, bus.sample_cnt, bus.busy} !== '0)
      $display("FAIL midrst_outputs x=%h ldx=%b stm=%b od=%h ov=%b err=%b cnt=%h busy=%b want all 0",
               bus.x_out, bus.ldx, bus.stm, bus.out_data, bus.out_valid, bus.err, bus.sample_cnt, bus.busy);
    else n_pass++;
    n_total++;
    if (bus.mac_n !== 3'd5 || bus.mac_s !== 6'd0)
      $display("FAIL midrst_cfg mac_n=%0d mac_s=%0d want 5 0", bus.mac_n, bus.mac_s);
    else n_pass++;
    for (int i = 0; i < 25; i++) begin
      step();
      if (bus.out_valid || bus.busy) ov++;
    end
    n_total++;
    if (ov != 0 || bus.sample_cnt !== 16'd0)
      $display("FAIL midrst_stale_eof active=%0d cnt=%0d want 0 0", ov, bus.sample_cnt);
    else n_pass++;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_n     = '0;
    bus.cfg_s     = '0;
    bus.mac_y     = '0;
    bus.mac_eof   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_random_stream();
    test_config();
    test_watchdog();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fir_stream_sequencer.md
Name: fir_stream_sequencer

Overview:
- Stream-side controller that sequences the FIR datapath (tap delay line + MAC + coefficient ROM) one sample at a time.
- Accepts input samples over a valid/ready handshake, pulses the delay-line load, starts the MAC and waits for its end-of-filter flag.
- Captures the MAC result into a held output with valid/ready backpressure.
- Holds the tap-count/shift configuration and a watchdog that aborts a hung MAC.

Parameters:
bits_X, 16, input sample width
bits_Y, 16, output sample width
bits_N, 3, MAC iteration-count width
bits_S, 6, MAC output shift-adjust width
bits_T, 8, watchdog counter width
TIMEOUT, 200, max cycles in WAIT before abort (must be < 2**bits_T)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
in_data  in  bits_X  input sample
in_valid  in  1  input sample valid
in_ready  out  1  sequencer can accept a sample
cfg_we  in  1  configuration write strobe
cfg_n  in  bits_N  iteration count to program
cfg_s  in  bits_S  shift adjust to program
x_out  out  bits_X  registered sample to head of delay line
ldx  out  1  delay-line shift/load pulse
stm  out  1  MAC start pulse
mac_n  out  bits_N  iteration count to MAC (= n_q)
mac_s  out  bits_S  shift adjust to MAC (= s_q)
mac_y  in  bits_Y  MAC result
mac_eof  in  1  MAC finished, mac_y valid this cycle
out_data  out  bits_Y  held filtered sample
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
busy  out  1  state != IDLE
err  out  1  sticky watchdog-timeout flag
sample_cnt  out  16  samples completed, wraps 0xFFFF->0

Behaviour:
- Reset (rst=1 at edge), regardless of state: state=IDLE; x_out=0, ldx=0, stm=0, out_data=0, out_valid=0, err=0, sample_cnt=0, watchdog=0, n_q=5, s_q=0. Reset mid-operation abandons the sample; any mac_eof arriving later while IDLE is ignored.
- States: IDLE, SHIFT, START, WAIT, OUT. All outputs are registered or decoded from the state register; no combinational in->out paths except in_ready.
- IDLE: in_ready=1. If in_valid=1: x_out<=in_data, go to SHIFT. A handshake is counted only when in_valid&in_ready.
- SHIFT: ldx=1 for exactly this cycle; next state START.
- START: stm=1 for exactly this cycle; watchdog cleared; next state WAIT.
- WAIT: watchdog increments each cycle.
  - If mac_eof=1: out_data<=mac_y, out_valid<=1, sample_cnt+=1, go to OUT.
  - Else if watchdog reaches TIMEOUT-1: err<=1, go to IDLE, out_valid stays 0.
  - mac_eof takes priority over timeout when both occur in the same cycle.
- OUT: out_valid=1 and out_data stable until out_ready=1. On out_valid&out_ready: out_valid<=0, go to IDLE.
- in_ready=0 in every state except IDLE, so at most one sample is in flight.
- Minimum period is 5 cycles plus MAC latency per sample (IDLE, SHIFT, START, WAIT>=1, OUT>=1).
- Config:
  - cfg_we in IDLE with no in_valid: n_q<=cfg_n, s_q<=cfg_s, effective from the next sample.
  - cfg_we in IDLE together with in_valid: config is applied, the sample is accepted, and that sample uses the new config.
  - cfg_we in any other state: ignored, registers unchanged.
- mac_n and mac_s are driven continuously from n_q and s_q.
- err is cleared only by rst.
- mac_eof outside WAIT is ignored.
- ldx and stm are never high in the same cycle.

Test Plan:
- Reset then single sample: in_data=0x1234 valid 1 cycle -> in_ready=1 that cycle; next cycle x_out=0x1234, ldx=1; cycle after stm=1. MAC model asserts mac_eof with mac_y=0x0ABC 6 cycles later -> out_valid=1, out_data=0x0ABC, sample_cnt=1, busy=1 until accepted.
- Backpressure: out_ready held 0 for 10 cycles after out_valid -> out_data holds 0x0ABC, in_ready=0 throughout; out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- Back-to-back stream: in_valid constant, 8 samples 1..8, MAC echoes x*2, out_ready=1 -> outputs 2,4,...,16 in order; exactly one ldx and one stm pulse per sample; sample_cnt=8.
- Config: cfg_we with cfg_n=3, cfg_s=4 in IDLE -> mac_n=3, mac_s=4. cfg_we with cfg_n=7 during WAIT -> mac_n stays 3.
- Watchdog: TIMEOUT=200, MAC never asserts eof -> exactly 200 cycles after entering WAIT, err=1, state IDLE, out_valid=0. A late mac_eof is ignored. rst clears err.
- Reset mid-WAIT: assert rst 3 cycles into WAIT -> all outputs at reset values next cycle; a subsequent mac_eof produces no out_valid.
